led_driver: RTL and testbench



---
 rtl/led_driver.sv | 136 +++++++++++++
 tb/tb_led_driver.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/led_driver.sv
// PWM-dimmed LED driver: accepts OFF/SOLID/BLINK/CHASE commands with a brightness
// level and switches to them only at a PWM-period boundary so the LEDs never glitch.
module led_driver #(
  parameter int TICK_DIV   = 100000,
  parameter int STEP_TICKS = 250,
  parameter int NUM_LEDS   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_mode,
  input  logic [7:0]          cmd_level,
  output logic [NUM_LEDS-1:0] led
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_SOLID = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_CHASE = 2'd3
  } mode_t;

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam int CW = $clog2(NUM_LEDS);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STEP_MAX  = SW'(STEP_TICKS - 1);
  localparam logic [CW-1:0] CHASE_MAX = CW'(NUM_LEDS - 1);

  logic [7:0]          r_pwm_cnt;
  mode_t               r_mode;
  logic [7:0]          r_level;
  mode_t               r_pend_mode;
  logic [7:0]          r_pend_level;
  logic                r_pend;
  logic                r_ready;
  logic [PW-1:0]       r_presc;
  logic [SW-1:0]       r_step_cnt;
  logic                r_phase;
  logic [CW-1:0]       r_chase_idx;
  logic [NUM_LEDS-1:0] r_led;

  logic                w_accept;
  logic                w_apply;
  logic                w_tick;
  logic                w_step;
  logic                w_pwm_on;
  logic [NUM_LEDS-1:0] w_chase_mask;
  logic [NUM_LEDS-1:0] w_mask;

  assign w_accept = cmd_valid & r_ready;
  assign w_apply  = (r_pwm_cnt == 8'hFF) & r_pend;
  assign w_tick   = (r_presc == PRESC_MAX);
  assign w_step   = w_tick & (r_step_cnt == STEP_MAX);
  assign w_pwm_on = (r_pwm_cnt < r_level);

  generate
    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_chase
      assign w_chase_mask[gi] = (r_chase_idx == CW'(gi));
    end
  endgenerate

  always_comb begin
    w_mask = '0;
    case (r_mode)
      MODE_OFF:   w_mask = '0;
      MODE_SOLID: w_mask = '1;
      MODE_BLINK: w_mask = r_phase ? '1 : '0;
      MODE_CHASE: w_mask = w_chase_mask;
      default:    w_mask = '0;
    endcase
  end

  // Pending command is held until the next PWM wrap; ready is simply "no pending".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt    <= 8'd0;
      r_mode       <= MODE_OFF;
      r_level      <= 8'd0;
      r_pend_mode  <= MODE_OFF;
      r_pend_level <= 8'd0;
      r_pend       <= 1'b0;
      r_ready      <= 1'b1;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
      if (w_accept) begin
        r_pend_mode  <= mode_t'(cmd_mode);
        r_pend_level <= cmd_level;
        r_pend       <= 1'b1;
        r_ready      <= 1'b0;
      end else if (w_apply) begin
        r_mode  <= r_pend_mode;
        r_level <= r_pend_level;
        r_pend  <= 1'b0;
        r_ready <= 1'b1;
      end
    end
  end

  // An apply restarts the animation timebase and suppresses any coincident step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc     <= '0;
      r_step_cnt  <= '0;
      r_phase     <= 1'b1;
      r_chase_idx <= '0;
    end else if (w_apply) begin
      r_presc     <= '0;
      r_step_cnt  <= '0;
      r_phase     <= 1'b1;
      r_chase_idx <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick) begin
        r_step_cnt <= w_step ? '0 : r_step_cnt + SW'(1);
      end
      if (w_step) begin
        r_phase     <= ~r_phase;
        r_chase_idx <= (r_chase_idx == CHASE_MAX) ? '0 : r_chase_idx + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led <= '0;
    end else begin
      r_led <= w_mask & {NUM_LEDS{w_pwm_on}};
    end
  end

  assign cmd_ready = r_ready;
  assign led       = r_led;

endmodule

// File: tb/tb_led_driver.sv
// Directed bench for led_driver with TICK_DIV=4, STEP_TICKS=2 (one step per 8 cycles).
module tb_led_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [7:0] cmd_level;
  logic [3:0] led;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] tb_pwm;   // expected DUT pwm_cnt in the current cycle
  int         n;        // cycles since the cycle with pwm_cnt==0 after the last apply

  always #5 clk = ~clk;

  led_driver #(
    .TICK_DIV  (4),
    .STEP_TICKS(2),
    .NUM_LEDS  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_mode (cmd_mode),
    .cmd_level(cmd_level),
    .led      (led)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (pwm=%0d n=%0d)", tag, obs, want, tb_pwm, n);
    end
  endtask

  // Expected mask-and-PWM value computed for animation cycle m after apply.
  function automatic logic [3:0] exp_led(input int mode, input int lvl, input int m);
    logic [3:0] mask;
    case (mode)
      1:       mask = 4'hF;
      2:       mask = (((m / 8) % 2) == 0) ? 4'hF : 4'h0;
      3:       mask = 4'b0001 << ((m / 8) % 4);
      default: mask = 4'h0;
    endcase
    return ((m % 256) < lvl) ? mask : 4'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    tb_pwm++;
    n++;
  endtask

  task automatic align(input logic [7:0] p);
    while (tb_pwm != p) tick();
  endtask

  task automatic accept(input logic [1:0] m, input logic [7:0] l);
    cmd_mode  = m;
    cmd_level = l;
    cmd_valid = 1'b1;
    chk("ready_before_accept", {7'd0, cmd_ready}, 8'd1);
    tick();
    cmd_valid = 1'b0;
    chk("ready_after_accept", {7'd0, cmd_ready}, 8'd0);
  endtask

  task automatic wait_apply();
    while (tb_pwm != 8'd255) begin
      chk("ready_while_pending", {7'd0, cmd_ready}, 8'd0);
      tick();
    end
    chk("ready_at_wrap", {7'd0, cmd_ready}, 8'd0);
    tick();
    n = 0;
    chk("ready_after_apply", {7'd0, cmd_ready}, 8'd1);
    chk("led_reflects_pwm255", {4'd0, led}, 8'd0);
  endtask

  task automatic run_mode(input string tag, input int mode, input int lvl,
                          input int cycles, input int exp_high);
    int high;
    high = 0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      chk(tag, {4'd0, led}, {4'd0, exp_led(mode, lvl, n - 1)});
      if (led != 4'h0) high++;
    end
    if (exp_high >= 0) chk({tag, "_high_count"}, 8'(high), 8'(exp_high));
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_mode  = 2'd0;
    cmd_level = 8'd0;
    tb_pwm    = 8'd0;
    n         = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_led", {4'd0, led}, 8'd0);
    chk("reset_ready", {7'd0, cmd_ready}, 8'd1);
    @(negedge clk);
    rst_n  = 1'b1;
    tb_pwm = 8'd0;
    n      = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("off_after_reset", {4'd0, led}, 8'd0);
    end

    // SOLID at three levels; the tb pwm count doubles as a check that pwm_cnt started at 0
    accept(2'd1, 8'd64);
    wait_apply();
    run_mode("solid64", 1, 64, 256, 64);

    accept(2'd1, 8'd0);
    wait_apply();
    run_mode("solid0", 1, 0, 256, 0);

    accept(2'd1, 8'd255);
    wait_apply();
    run_mode("solid255", 1, 255, 256, 255);

    accept(2'd2, 8'd255);
    wait_apply();
    run_mode("blink255", 2, 255, 40, -1);

    accept(2'd3, 8'd255);
    wait_apply();
    run_mode("chase255", 3, 255, 40, -1);

    // Accepted in the pwm==255 cycle: must wait a full period before applying
    align(8'd255);
    accept(2'd1, 8'd255);
    chk("wrap_accept_not_applied_led", {4'd0, led}, 8'd0);
    wait_apply();
    run_mode("wrap_accept_solid", 1, 255, 64, -1);

    // Backpressure: B held valid while A is pending
    align(8'd0);
    accept(2'd1, 8'd64);
    cmd_mode  = 2'd3;
    cmd_level = 8'd128;
    cmd_valid = 1'b1;
    wait_apply();
    tick();
    cmd_valid = 1'b0;
    chk("b_accepted_after_a_apply", {7'd0, cmd_ready}, 8'd0);
    while (tb_pwm != 8'd255) begin
      chk("a_active_solid64", {4'd0, led}, {4'd0, exp_led(1, 64, n - 1)});
      tick();
    end
    wait_apply();
    run_mode("b_chase128", 3, 128, 48, -1);

    // Reset with a command pending: it must never apply
    accept(2'd1, 8'd255);
    repeat (4) tick();
    chk("pre_reset_led_lit", {7'd0, (led != 4'h0)}, 8'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_reset_led", {4'd0, led}, 8'd0);
    chk("async_reset_ready", {7'd0, cmd_ready}, 8'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    tb_pwm = 8'd0;
    n      = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      chk("pending_discarded_led", {4'd0, led}, 8'd0);
      chk("pending_discarded_ready", {7'd0, cmd_ready}, 8'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
